seq_div16: RTL and testbench
============================

Name: seq_div16

Overview:
- Multi-cycle restoring divider: quotient and remainder of an unsigned dividend by an unsigned divisor.
- One subtract-and-compare step per clock. This is the inverse of the adder datapath: each step subtracts the divisor and restores the partial remainder on borrow.
- Sits beside the combinational 16-bit adder blocks in the arithmetic unit.
- Uses a start/busy/done handshake so the surrounding controller can issue one divide at a time.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- busy  output  1  high while a divide is in progress (CALC state).
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH  result quotient; held until next accepted start.
- remainder  output  WIDTH  result remainder; held until next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and registers cleared.
  - Reset mid-operation aborts the divide with no done pulse.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 captures dividend and divisor.
  - Partial remainder cleared; shift register loaded with dividend; count=WIDTH-1; busy=1 next cycle; next state CALC.
  - start=0: stay in IDLE with outputs held.
- Divisor==0 at capture:
  - Skip CALC and go directly to FINISH.
  - Results: quotient = all ones (2^WIDTH-1), remainder = dividend, div_by_zero=1.
- CALC, one iteration per cycle:
  - trial = {partial_rem[WIDTH-2:0], msb of shift reg} - divisor, computed at WIDTH+1 bits to detect borrow.
  - No borrow: partial_rem=trial and shift in quotient bit 1.
  - Borrow: partial_rem keeps the shifted value (restore) and shift in quotient bit 0.
  - count decrements each cycle. When count==0 after that cycle's update, next state is FINISH.
- FINISH:
  - quotient/remainder registers updated; done=1 for exactly this one cycle; busy=0; next state IDLE.
- Latency:
  - Non-zero divisor: start accepted at edge N; done high in cycle N+WIDTH+1 (17 cycles for WIDTH=16).
  - Zero divisor: done high in cycle N+1.
- start while busy or in FINISH: ignored (not queued).
- start held high: a new divide begins on the first IDLE cycle after done (back-to-back throughput WIDTH+2 cycles).
- Operand inputs may change freely after capture; results depend only on the captured values.
- Outputs quotient, remainder and div_by_zero change only at FINISH or reset.
- Invariant for divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.

Optional Feature:
- Macro: SEQ_DIV16_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit, captured with start).
  - When signed_op=1, operands are two's complement. Magnitudes are divided by the same unsigned engine.
  - Quotient is negated if operand signs differ; remainder takes the sign of the dividend (truncating division).
  - Most-negative / -1 overflow: quotient = most-negative value, remainder=0, no flag.
  - Signed divide-by-zero: quotient = -1 (all ones), remainder = dividend.
  - Latency is unchanged: sign fix-up is done combinationally into the FINISH register load.
- Undefined: no signed_op port; unsigned only.

Test Plan:
- Reset then idle: rst for 2 cycles, start=0 -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 for 20 cycles.
- Basic unsigned: start with 1000/7 -> done exactly 17 cycles after accept, quotient=142, remainder=6, div_by_zero=0; busy high for 16 cycles.
- Boundaries:
  - 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 0xFFFF/0xFFFF -> quotient=1, remainder=0.
- Divide by zero: 1234/0 -> done 1 cycle after accept, quotient=0xFFFF, remainder=1234, div_by_zero=1; a following 10/2 clears the flag, giving quotient=5, remainder=0.
- Handshake and abort:
  - start pulsed again mid-CALC with new operands is ignored; first result (200/3 -> 66 rem 2) is unaffected.
  - rst asserted at cycle 8 of a divide -> no done pulse, state IDLE, outputs 0.
- Signed (SEQ_DIV16_SIGNED_EN):
  - -7/2 -> quotient=-3 (0xFFFD), remainder=-1 (0xFFFF).
  - 7/-2 -> quotient=-3, remainder=1.
  - 0x8000/0xFFFF -> quotient=0x8000, remainder=0.

Source files
------------

// File: rtl/seq_div16.sv
// seq_div16: multi-cycle restoring divider, one subtract-and-compare step per clock.
// Produces quotient and remainder of dividend / divisor with a start/busy/done
// handshake. Define SEQ_DIV16_SIGNED_EN to add a signed_op input that selects
// two's-complement (truncating) division on the same unsigned engine.
module seq_div16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_DIV16_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;     // partial remainder
  logic [WIDTH-1:0] shf_q;     // dividend bits out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dsr_q;     // captured divisor magnitude
  logic [WIDTH-1:0] dvd_q;     // captured dividend as presented (divide-by-zero remainder)
  logic             dbz_q;     // captured divisor was zero
  logic             neg_quo_q; // negate quotient at FINISH
  logic             neg_rem_q; // negate remainder at FINISH

  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             dbz_out_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic             neg_quo;
  logic             neg_rem;
  logic             dsr_zero;

  logic [WIDTH-1:0] res_quo;
  logic [WIDTH-1:0] res_rem;

  // Operand conditioning at capture: magnitudes and result sign flags.
  always_comb begin
    dvd_mag  = dividend;
    dsr_mag  = divisor;
    neg_quo  = 1'b0;
    neg_rem  = 1'b0;
    dsr_zero = (divisor == '0);
`ifdef SEQ_DIV16_SIGNED_EN
    if (signed_op) begin
      if (dividend[WIDTH-1]) begin
        dvd_mag = '0 - dividend;
      end
      if (divisor[WIDTH-1]) begin
        dsr_mag = '0 - divisor;
      end
      neg_quo = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem = dividend[WIDTH-1];
    end
`endif
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // The top bit of rem_q can be dropped: before the last step the remainder is
  // bounded by the consumed dividend prefix, which is below 2^(WIDTH-1).
  always_comb begin
    shifted = {1'b0, rem_q[WIDTH-2:0], shf_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    borrow  = trial[WIDTH];
  end

  // Result formation for the FINISH load, including sign fix-up and divide-by-zero.
  always_comb begin
    res_quo = shf_q;
    res_rem = rem_q;
    if (dbz_q) begin
      res_quo = '1;
      res_rem = dvd_q;
    end else begin
      if (neg_quo_q) begin
        res_quo = '0 - shf_q;
      end
      if (neg_rem_q) begin
        res_rem = '0 - rem_q;
      end
    end
  end

  // Control state machine and iteration counter.
  // cnt is loaded with WIDTH-1 and the last step is the one taken with cnt==0,
  // giving exactly WIDTH CALC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= CW'(WIDTH - 1);
            state <= dsr_zero ? S_FINISH : S_CALC;
          end
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath registers: operand capture in IDLE, shift/subtract in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      shf_q     <= '0;
      dsr_q     <= '0;
      dvd_q     <= '0;
      dbz_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (start) begin
          rem_q     <= '0;
          shf_q     <= dvd_mag;
          dsr_q     <= dsr_mag;
          dvd_q     <= dividend;
          dbz_q     <= dsr_zero;
          neg_quo_q <= neg_quo;
          neg_rem_q <= neg_rem;
        end
      end else if (state == S_CALC) begin
        shf_q <= {shf_q[WIDTH-2:0], ~borrow};
        rem_q <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      end
    end
  end

  // Result registers and done pulse, loaded only in FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_FINISH) begin
        done_q    <= 1'b1;
        quo_q     <= res_quo;
        rmd_q     <= res_rem;
        dbz_out_q <= dbz_q;
      end
    end
  end

  assign busy        = (state == S_CALC);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_div16.sv
// tb_seq_div16: directed and randomized checks of seq_div16 against an
// arithmetic reference model (/ and % on integers).
module tb_seq_div16;

  localparam int unsigned WIDTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
`ifdef SEQ_DIV16_SIGNED_EN
  logic        signed_op;
`endif
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div16 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef SEQ_DIV16_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating integer division; zero divisor gives all-ones / dividend.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input bit sop,
                                output logic [15:0] q, output logic [15:0] r, output logic z);
    int sa, sb, sq, sr;
    if (b == 16'd0) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else if (sop) begin
      sa = $signed(a);
      sb = $signed(b);
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[15:0];
      r  = sr[15:0];
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // One divide: issue start, optionally re-pulse start at sample index poke,
  // scramble operands after capture, and check latency, busy time and results.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input bit sop,
                         input int poke, input string tag);
    logic [15:0] eq, er, hq;
    logic        ez;
    int          cyc, busy_cnt;
    model(a, b, sop, eq, er, ez);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
`ifdef SEQ_DIV16_SIGNED_EN
    signed_op = sop;
`endif
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
`ifdef SEQ_DIV16_SIGNED_EN
    signed_op = 1'($urandom);
`endif
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (poke != 0 && cyc == poke) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 16'($urandom_range(1, 100));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (busy === 1'b1) busy_cnt++;
    end
    chk({tag, "_latency"}, cyc, (b == 16'd0) ? 1 : 17);
    chk({tag, "_busy_cycles"}, busy_cnt, (b == 16'd0) ? 0 : 16);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    hq = quotient;
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle_after"}, busy, 1'b0);
    chk({tag, "_held"}, quotient, hq);
  endtask

  initial begin
    int cyc, t1, t2, ndone, sel;
    logic [15:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIV16_SIGNED_EN
    signed_op = 1'b0;
`endif

    // Reset for two cycles then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_quotient", quotient, 16'd0);
      chk("rst_remainder", remainder, 16'd0);
      chk("rst_dbz", div_by_zero, 1'b0);
    end

    // Basic and boundary divides.
    run_div(16'd1000, 16'd7,    1'b0, 0, "basic");
    run_div(16'hFFFF, 16'd1,    1'b0, 0, "max_by_1");
    run_div(16'd5,    16'd9,    1'b0, 0, "small_by_big");
    run_div(16'hFFFF, 16'hFFFF, 1'b0, 0, "max_by_max");
    run_div(16'hFFFF, 16'h8001, 1'b0, 0, "max_by_8001");

    // Divide by zero, then a normal divide clears the flag.
    run_div(16'd1234, 16'd0, 1'b0, 0, "dbz");
    run_div(16'd10,   16'd2, 1'b0, 0, "after_dbz");

    // start re-pulsed during CALC and during FINISH is ignored.
    run_div(16'd200, 16'd3, 1'b0, 5,  "poke_calc");
    run_div(16'd999, 16'd4, 1'b0, 16, "poke_finish");

    // Reset at cycle 8 of a divide aborts without done.
    @(negedge clk);
    dividend = 16'hABCD;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_quotient", quotient, 16'd0);
    chk("abort_remainder", remainder, 16'd0);
    chk("abort_dbz", div_by_zero, 1'b0);
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", busy, 1'b0);

    // start held high: back-to-back divides every WIDTH+2 cycles.
    @(negedge clk);
    dividend = 16'd600;
    divisor  = 16'd25;
    start    = 1'b1;
    cyc = 0;
    t1  = -1;
    t2  = -1;
    while (t2 < 0 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_first_done", t1, 18);
    chk("b2b_interval", t2 - t1, 18);
    chk("b2b_quotient", quotient, 16'd24);
    chk("b2b_remainder", remainder, 16'd0);
    @(posedge clk);
    #1;
    chk("b2b_stopped", busy, 1'b0);

`ifdef SEQ_DIV16_SIGNED_EN
    run_div(16'hFFF9, 16'd2,    1'b1, 0, "s_neg7_by_2");
    run_div(16'd7,    16'hFFFE, 1'b1, 0, "s_7_by_neg2");
    run_div(16'h8000, 16'hFFFF, 1'b1, 0, "s_overflow");
    run_div(16'hFF00, 16'd0,    1'b1, 0, "s_dbz");
    run_div(16'hFFF9, 16'd2,    1'b0, 0, "u_fff9_by_2");
`endif

    // Randomized divides, biased toward zero and small divisors.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra  = 16'($urandom);
      if (sel == 0) rb = 16'd0;
      else if (sel < 4) rb = 16'($urandom_range(1, 15));
      else rb = 16'($urandom);
`ifdef SEQ_DIV16_SIGNED_EN
      run_div(ra, rb, 1'($urandom), 0, "rand");
`else
      run_div(ra, rb, 1'b0, 0, "rand");
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
